// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@60 timing constants, frame-buffer geometry and scan types
package vga_pkg;
  typedef logic [10:0] hcnt_t;
  typedef logic [9:0] vcnt_t;
  typedef logic [17:0] baddr_t;
  typedef struct packed {
    logic fs;
    logic vs;
    logic hs;
    logic odd;
    logic win;
    logic act;
  } vflags_t;
  localparam hcnt_t H_ACTIVE = 11'd800;
  localparam hcnt_t H_FP = 11'd40;
  localparam hcnt_t H_SYNC = 11'd128;
  localparam hcnt_t H_BP = 11'd88;
  localparam hcnt_t H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam vcnt_t V_ACTIVE = 10'd600;
  localparam vcnt_t V_FP = 10'd1;
  localparam vcnt_t V_SYNC = 10'd4;
  localparam vcnt_t V_BP = 10'd23;
  localparam vcnt_t V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam baddr_t BUF_W = 18'd800;
  localparam vcnt_t BUF_H = 10'd240;
  localparam vcnt_t V_OFFSET = 10'd60;
  localparam int RD_LAT = 2;
  localparam logic [3:0] FG_LEVEL = 4'hF;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with raw active, sync, buffer-window and line-parity flags
module vga_timing
  import vga_pkg::*;
#(
  parameter hcnt_t H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter hcnt_t H_FP = vga_pkg::H_FP,
  parameter hcnt_t H_SYNC = vga_pkg::H_SYNC,
  parameter hcnt_t H_BP = vga_pkg::H_BP,
  parameter vcnt_t V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter vcnt_t V_FP = vga_pkg::V_FP,
  parameter vcnt_t V_SYNC = vga_pkg::V_SYNC,
  parameter vcnt_t V_BP = vga_pkg::V_BP,
  parameter vcnt_t BUF_H = vga_pkg::BUF_H,
  parameter vcnt_t V_OFFSET = vga_pkg::V_OFFSET
) (
  input logic pixclk,
  input logic reset,
  output hcnt_t hcount,
  output logic h_end,
  output vflags_t flags
);
  localparam hcnt_t HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam vcnt_t VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam hcnt_t HS0 = H_ACTIVE + H_FP;
  localparam vcnt_t VS0 = V_ACTIVE + V_FP;
  localparam vcnt_t WIN_END = V_OFFSET + BUF_H + BUF_H;
  vcnt_t vcount;
  assign h_end = hcount == HT - hcnt_t'(1);
  always_ff @(posedge pixclk or posedge reset)
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_end ? '0 : hcount + hcnt_t'(1);
      if (h_end) vcount <= (vcount == VT - vcnt_t'(1)) ? '0 : vcount + vcnt_t'(1);
    end
  // parity of (vcount - V_OFFSET) selects the first or second repeat of a buffer line
  always_comb begin
    flags.act = hcount < H_ACTIVE && vcount < V_ACTIVE;
    flags.hs = hcount >= HS0 && hcount < HS0 + H_SYNC;
    flags.vs = vcount >= VS0 && vcount < VS0 + V_SYNC;
    flags.win = vcount >= V_OFFSET && vcount < WIN_END;
    flags.odd = vcount[0] ^ V_OFFSET[0];
    flags.fs = hcount == '0 && vcount == '0;
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: reads the m4_input frame buffer and drives 800x600@60 VGA, each buffer line shown twice
// SCANLINES_EN: the second repeat of every buffer line is shown at half intensity
module vga_scanout
  import vga_pkg::*;
#(
  parameter hcnt_t H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter hcnt_t H_FP = vga_pkg::H_FP,
  parameter hcnt_t H_SYNC = vga_pkg::H_SYNC,
  parameter hcnt_t H_BP = vga_pkg::H_BP,
  parameter vcnt_t V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter vcnt_t V_FP = vga_pkg::V_FP,
  parameter vcnt_t V_SYNC = vga_pkg::V_SYNC,
  parameter vcnt_t V_BP = vga_pkg::V_BP,
  parameter baddr_t BUF_W = vga_pkg::BUF_W,
  parameter vcnt_t BUF_H = vga_pkg::BUF_H,
  parameter vcnt_t V_OFFSET = vga_pkg::V_OFFSET,
  parameter int RD_LAT = vga_pkg::RD_LAT,
  parameter logic [3:0] FG_LEVEL = vga_pkg::FG_LEVEL
) (
  input logic pixclk,
  input logic reset,
  output baddr_t raddr,
  output logic rden,
  input logic rdata,
  output logic hsync,
  output logic vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic frame_start
);
`ifdef SCANLINES_EN
  localparam logic SCAN = 1'b1;
`else
  localparam logic SCAN = 1'b0;
`endif
  hcnt_t hcount;
  logic h_end;
  vflags_t cur, o;
  baddr_t line_base, raddr_q;
  logic [3:0] lvl;
  vflags_t pipe [RD_LAT];
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BUF_H(BUF_H), .V_OFFSET(V_OFFSET)
  ) u_timing (
    .pixclk(pixclk),
    .reset(reset),
    .hcount(hcount),
    .h_end(h_end),
    .flags(cur)
  );
  assign rden = cur.act && cur.win;
  assign raddr = rden ? line_base + baddr_t'(hcount) : raddr_q;
  // base is zero outside the window and steps one buffer line after each second repeat
  always_ff @(posedge pixclk or posedge reset)
    if (reset) begin
      line_base <= '0;
      raddr_q <= '0;
    end else begin
      raddr_q <= raddr;
      line_base <= !cur.win ? '0 : (h_end && cur.odd) ? line_base + BUF_W : line_base;
    end
  always_ff @(posedge pixclk or posedge reset)
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign o = pipe[RD_LAT-1];
  assign lvl = (SCAN && o.odd) ? FG_LEVEL >> 1 : FG_LEVEL;
  assign {red, green, blue} = {3{(o.act && o.win && rdata) ? lvl : 4'h0}};
  assign hsync = o.hs;
  assign vsync = o.vs;
  assign frame_start = o.fs;
endmodule
